// File: rtl/nbload_scoreboard_pkg.sv
// Shared types for the non-blocking-load scoreboard: entry record, legacy CAM
// packet with a configurable tag width, and the rd-compare helper.
package nbload_scoreboard_pkg;

  localparam int RD_W = 5;

  localparam int NBLOAD_TAG_W = 2;

  typedef struct packed {
    logic            valid;
    logic            wb;
    logic [RD_W-1:0] rd;
  } nbload_entry_t;

  typedef struct packed {
    logic                    valid;
    logic                    wb;
    logic [NBLOAD_TAG_W-1:0] tag;
    logic [RD_W-1:0]         rd;
  } load_cam_pkt_t;

  // x0 never carries a hazard, so a zero rd never matches anything.
  function automatic logic rd_match(input logic [RD_W-1:0] a, input logic [RD_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/nbload_scoreboard_if.sv
// Issue/LSU-side bundle of the non-blocking-load scoreboard.
interface nbload_scoreboard_if #(
  parameter int DEPTH      = 4,
  parameter int NUM_RET    = 2,
  parameter int NUM_LOOKUP = 6
) ();
  import nbload_scoreboard_pkg::*;
  localparam int TAG_W = $clog2(DEPTH);

  logic                                alloc_valid;
  logic [RD_W-1:0]                     alloc_rd;
  logic                                alloc_ready;
  logic [TAG_W-1:0]                    alloc_tag;
  logic                                kill_valid;
  logic [RD_W-1:0]                     kill_rd;
  logic                                cancel_valid;
  logic [TAG_W-1:0]                    cancel_tag;
  logic                                flush_all;
  logic [NUM_RET-1:0]                  ret_valid;
  logic [NUM_RET-1:0][TAG_W-1:0]       ret_tag;
  logic [NUM_RET-1:0]                  wb_valid;
  logic [NUM_RET-1:0][RD_W-1:0]        wb_rd;
  logic [NUM_LOOKUP-1:0][RD_W-1:0]     lookup_rd;
  logic [NUM_LOOKUP-1:0]               lookup_hit;
  logic                                busy;
  logic [TAG_W:0]                      count;
  logic                                err_spurious;
  logic                                err_overflow;

  modport master (
    output alloc_valid, alloc_rd, kill_valid, kill_rd, cancel_valid, cancel_tag,
           flush_all, ret_valid, ret_tag, lookup_rd,
    input  alloc_ready, alloc_tag, wb_valid, wb_rd, lookup_hit, busy, count,
           err_spurious, err_overflow
  );

  modport slave (
    input  alloc_valid, alloc_rd, kill_valid, kill_rd, cancel_valid, cancel_tag,
           flush_all, ret_valid, ret_tag, lookup_rd,
    output alloc_ready, alloc_tag, wb_valid, wb_rd, lookup_hit, busy, count,
           err_spurious, err_overflow
  );
endinterface

// File: rtl/nbload_prio_enc.sv
// Lowest-set-index priority encoder; picks the free scoreboard entry to allocate.
module nbload_prio_enc #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     found
);
  localparam int TAG_W = $clog2(DEPTH);

  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (req[i]) idx = TAG_W'(i);
    end
  end
endmodule

// File: rtl/nbload_scoreboard.sv
// Outstanding non-blocking-load tracker: tag allocation, WAW/flush kill of
// write-back, multi-channel returns and combinational RAW lookups.
module nbload_scoreboard
  import nbload_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int NUM_RET    = 2,
  parameter int NUM_LOOKUP = 6
) (
  input logic                clk,
  input logic                rst_l,
  nbload_scoreboard_if.slave sb
);
  localparam int TAG_W = $clog2(DEPTH);

  nbload_entry_t                ent_q [DEPTH];
  nbload_entry_t                ent_d [DEPTH];
  logic [DEPTH-1:0]             free_vec;
  logic [DEPTH-1:0]             freed_vec;
  logic [TAG_W-1:0]             free_idx;
  logic                         free_any;
  logic                         alloc_fire;
  logic                         cancel_ok;
  logic                         spur_now;
  logic [NUM_RET-1:0]           wbv_d;
  logic [NUM_RET-1:0][RD_W-1:0] wbrd_d;
  logic [TAG_W:0]               cnt_d;
  logic [NUM_LOOKUP-1:0]        hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_free
    assign free_vec[i] = !ent_q[i].valid;
  end

  nbload_prio_enc #(.DEPTH(DEPTH)) u_prio (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_any)
  );

  // Flush drops a same-cycle allocation but leaves alloc_ready alone.
  assign alloc_fire     = sb.alloc_valid & free_any & !sb.flush_all;
  assign sb.alloc_ready = free_any;
  assign sb.alloc_tag   = free_idx;

  // Returns and cancel: walk channels in order so the lowest channel claims a
  // tag first; any later claim on the same tag is treated as spurious.
  always_comb begin
    freed_vec = '0;
    spur_now  = 1'b0;
    wbv_d     = '0;
    wbrd_d    = '0;
    cancel_ok = 1'b0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (sb.ret_valid[k]) begin
        if (ent_q[sb.ret_tag[k]].valid && !freed_vec[sb.ret_tag[k]]) begin
          freed_vec[sb.ret_tag[k]] = 1'b1;
          wbv_d[k]  = ent_q[sb.ret_tag[k]].wb & !sb.flush_all
                    & !(sb.kill_valid && rd_match(sb.kill_rd, ent_q[sb.ret_tag[k]].rd))
                    & !(sb.cancel_valid && (sb.cancel_tag == sb.ret_tag[k]));
          wbrd_d[k] = ent_q[sb.ret_tag[k]].rd;
        end else begin
          spur_now = 1'b1;
        end
      end
    end
    if (sb.cancel_valid) begin
      if (ent_q[sb.cancel_tag].valid) begin
        cancel_ok = 1'b1;
        freed_vec[sb.cancel_tag] = 1'b1;
      end else begin
        spur_now = 1'b1;
      end
    end
  end

  // Next entry state. The allocated slot was free at the start of the cycle,
  // so it never collides with a slot being freed.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (alloc_fire && (free_idx == TAG_W'(i))) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].wb    = (sb.alloc_rd != '0);
        ent_d[i].rd    = sb.alloc_rd;
      end else if (freed_vec[i]) begin
        ent_d[i] = '0;
      end else if (ent_q[i].valid &&
                   (sb.flush_all ||
                    (sb.kill_valid && rd_match(sb.kill_rd, ent_q[i].rd)) ||
                    (alloc_fire && rd_match(sb.alloc_rd, ent_q[i].rd)))) begin
        ent_d[i].wb = 1'b0;
      end
      cnt_d = cnt_d + (TAG_W+1)'(ent_d[i].valid);
    end
  end

  // RAW lookup sees registered state only; no same-cycle forwarding.
  always_comb begin
    hit = '0;
    for (int j = 0; j < NUM_LOOKUP; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && ent_q[i].wb && rd_match(sb.lookup_rd[j], ent_q[i].rd))
          hit[j] = 1'b1;
      end
    end
  end
  assign sb.lookup_hit = hit;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      sb.wb_valid     <= '0;
      sb.wb_rd        <= '0;
      sb.count        <= '0;
      sb.busy         <= 1'b0;
      sb.err_spurious <= 1'b0;
      sb.err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      sb.wb_valid     <= wbv_d;
      sb.wb_rd        <= wbrd_d;
      sb.count        <= cnt_d;
      sb.busy         <= (cnt_d != '0);
      sb.err_spurious <= sb.err_spurious | spur_now;
      sb.err_overflow <= sb.err_overflow | (sb.alloc_valid & !free_any);
    end
  end

endmodule
